// File: rtl/fifo_arbiter.sv
// fifo_arbiter: shares one FIFO between NUM_REQ producers (round-robin write grant),
// sequences the FIFO read side for a single consumer and owns the occupancy count.
// Optional build macro FIFO_ARB_WATCHDOG_EN adds a read-response watchdog (rd_timeout).
module fifo_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned LVL_W   = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      fifo_write,
    output logic [DATA_W-1:0]         fifo_data_write,
    output logic                      fifo_read,
    input  logic                      fifo_data_ready,
    input  logic [DATA_W-1:0]         fifo_data_read,
    input  logic                      pop_req,
    output logic                      pop_valid,
    output logic [DATA_W-1:0]         pop_data,
    output logic [LVL_W-1:0]          level,
    output logic                      full,
    output logic                      empty,
    output logic                      rd_busy,
    output logic                      rd_timeout
);

    localparam int unsigned      PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [LVL_W-1:0] CAP   = LVL_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ISSUE,
        RD_WAIT
    } rd_state_e;

    rd_state_e         rd_state_q, rd_state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              fifo_write_q, fifo_write_d;
    logic [DATA_W-1:0] fifo_data_write_q, fifo_data_write_d;
    logic              fifo_read_q, fifo_read_d;
    logic              pop_valid_q, pop_valid_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;

    logic              rd_start;   // read FSM leaves RD_IDLE this cycle
    logic              push_ok;
    logic              grant_vld;
    logic [PTR_W-1:0]  winner;
    logic [PTR_W-1:0]  cand;
    logic              wd_expire;

`ifdef FIFO_ARB_WATCHDOG_EN
    logic [2:0] wd_cnt_q, wd_cnt_d;
    logic       rd_timeout_q, rd_timeout_d;

    // Give up on a read response after the fourth silent RD_WAIT cycle.
    assign wd_expire = (rd_state_q == RD_WAIT) && !fifo_data_ready && (wd_cnt_q == 3'd3);

    // Watchdog counter, cleared on the way into RD_WAIT; timeout flag is sticky.
    always_comb begin
        wd_cnt_d     = wd_cnt_q;
        rd_timeout_d = rd_timeout_q | wd_expire;
        if (rd_state_q == RD_ISSUE) begin
            wd_cnt_d = 3'd0;
        end else if (rd_state_q == RD_WAIT) begin
            wd_cnt_d = wd_cnt_q + 3'd1;
        end
    end

    // Watchdog state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q     <= 3'd0;
            rd_timeout_q <= 1'b0;
        end else begin
            wd_cnt_q     <= wd_cnt_d;
            rd_timeout_q <= rd_timeout_d;
        end
    end

    assign rd_timeout = rd_timeout_q;
`else
    assign wd_expire  = 1'b0;
    assign rd_timeout = 1'b0;
`endif

    // Round-robin grant; a concurrent pull frees a slot so a push is allowed even when full.
    always_comb begin
        rd_start  = !reset && (rd_state_q == RD_IDLE) && pop_req && (level_q != '0);
        push_ok   = !reset && ((level_q < CAP) || rd_start);
        grant_vld = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = PTR_W'((32'(rr_ptr_q) + off) % NUM_REQ);
            if (push_ok && !grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                winner    = cand;
            end
        end
        grant = '0;
        if (grant_vld) begin
            grant[winner] = 1'b1;
        end
    end

    // Push strobe, push data, pointer advance and occupancy bookkeeping.
    always_comb begin
        fifo_write_d      = grant_vld;
        fifo_data_write_d = fifo_data_write_q;
        rr_ptr_d          = rr_ptr_q;
        level_d           = level_q;
        if (grant_vld) begin
            fifo_data_write_d = req_data[32'(winner) * DATA_W +: DATA_W];
            rr_ptr_d          = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
        end
        if (grant_vld && !rd_start) begin
            level_d = level_q + LVL_W'(1);
        end else if (!grant_vld && rd_start) begin
            level_d = level_q - LVL_W'(1);
        end
        full_d  = (level_d == CAP);
        empty_d = (level_d == '0);
    end

    // Read sequencer: issue one pull, then wait for the FIFO's completion pulse.
    always_comb begin
        rd_state_d  = rd_state_q;
        pop_valid_d = 1'b0;
        pop_data_d  = pop_data_q;
        unique case (rd_state_q)
            RD_IDLE: begin
                if (rd_start) begin
                    rd_state_d = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                rd_state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (fifo_data_ready) begin
                    pop_data_d  = fifo_data_read;
                    pop_valid_d = 1'b1;
                    rd_state_d  = RD_IDLE;
                end else if (wd_expire) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: begin
                rd_state_d = RD_IDLE;
            end
        endcase
        fifo_read_d = (rd_state_d == RD_ISSUE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q        <= RD_IDLE;
            rr_ptr_q          <= '0;
            level_q           <= '0;
            full_q            <= 1'b0;
            empty_q           <= 1'b1;
            fifo_write_q      <= 1'b0;
            fifo_data_write_q <= '0;
            fifo_read_q       <= 1'b0;
            pop_valid_q       <= 1'b0;
            pop_data_q        <= '0;
        end else begin
            rd_state_q        <= rd_state_d;
            rr_ptr_q          <= rr_ptr_d;
            level_q           <= level_d;
            full_q            <= full_d;
            empty_q           <= empty_d;
            fifo_write_q      <= fifo_write_d;
            fifo_data_write_q <= fifo_data_write_d;
            fifo_read_q       <= fifo_read_d;
            pop_valid_q       <= pop_valid_d;
            pop_data_q        <= pop_data_d;
        end
    end

    assign fifo_write      = fifo_write_q;
    assign fifo_data_write = fifo_data_write_q;
    assign fifo_read       = fifo_read_q;
    assign pop_valid       = pop_valid_q;
    assign pop_data        = pop_data_q;
    assign level           = level_q;
    assign full            = full_q;
    assign empty           = empty_q;
    assign rd_busy         = (rd_state_q != RD_IDLE);

endmodule

// File: tb/tb_fifo_arbiter.sv
// tb_fifo_arbiter: random producers/consumer against a transaction-level model of the
// arbiter plus a behavioural FIFO that answers pulls after a random delay.
module tb_fifo_arbiter;

    localparam int N   = 4;
    localparam int CAP = 15;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   grant;
    logic           fifo_write;
    logic [7:0]     fifo_data_write;
    logic           fifo_read;
    logic           fifo_data_ready;
    logic [7:0]     fifo_data_read;
    logic           pop_req;
    logic           pop_valid;
    logic [7:0]     pop_data;
    logic [4:0]     level;
    logic           full;
    logic           empty;
    logic           rd_busy;
    logic           rd_timeout;

    always #5 clk = ~clk;

    fifo_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (8),
        .DEPTH   (16),
        .LVL_W   (5)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .req_data        (req_data),
        .grant           (grant),
        .fifo_write      (fifo_write),
        .fifo_data_write (fifo_data_write),
        .fifo_read       (fifo_read),
        .fifo_data_ready (fifo_data_ready),
        .fifo_data_read  (fifo_data_read),
        .pop_req         (pop_req),
        .pop_valid       (pop_valid),
        .pop_data        (pop_data),
        .level           (level),
        .full            (full),
        .empty           (empty),
        .rd_busy         (rd_busy),
        .rd_timeout      (rd_timeout)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Producers and stimulus knobs
    logic [N-1:0] p_req;
    logic [7:0]   p_data [N];
    int           req_pct;
    int           pop_pct;
    bit           fixed_data;
    bit           rst_drv;
    bit           hold_ready;

    // Behavioural FIFO on the far side of the arbiter
    logic [7:0] env_q[$];
    logic [7:0] env_rdata;
    int         rdy_cnt;

    // Transaction-level reference model (0 idle, 1 pull issued, 2 awaiting data)
    int         m_level, m_ptr, m_phase, m_wcnt;
    bit         m_to;
    logic [7:0] exp_q[$];
    logic [7:0] m_pend;
    bit         exp_fw, exp_fr, exp_pv;
    logic [7:0] exp_fdw, exp_pd;

    task automatic model_reset();
        m_level = 0; m_ptr = 0; m_phase = 0; m_wcnt = 0; m_to = 0;
        exp_fw = 0; exp_fr = 0; exp_pv = 0; exp_fdw = 8'h00; exp_pd = 8'h00;
        exp_q.delete();
    endtask

    task automatic drive();
        reset = rst_drv;
        req   = p_req;
        for (int i = 0; i < N; i++) req_data[i*8 +: 8] = p_data[i];
        pop_req         = ($urandom_range(0, 99) < pop_pct);
        fifo_data_ready = 1'b0;
        fifo_data_read  = 8'($urandom);
        if (rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0) begin
                fifo_data_ready = 1'b1;
                fifo_data_read  = env_rdata;
            end
        end
    endtask

    task automatic evaluate();
        int   g;
        bit   decide;
        logic [N-1:0] want_grant;
        g      = -1;
        decide = !reset && (m_phase == 0) && pop_req && (m_level > 0);
        if (!reset && ((m_level < CAP) || decide)) begin
            for (int off = 0; off < N; off++) begin
                if (g < 0 && p_req[(m_ptr + off) % N]) g = (m_ptr + off) % N;
            end
        end
        want_grant = '0;
        if (g >= 0) want_grant[g] = 1'b1;

        check_eq("grant", 32'(grant), 32'(want_grant));
        check_eq("fifo_write", 32'(fifo_write), 32'(exp_fw));
        if (exp_fw) check_eq("fifo_data_write", 32'(fifo_data_write), 32'(exp_fdw));
        check_eq("fifo_read", 32'(fifo_read), 32'(exp_fr));
        check_eq("pop_valid", 32'(pop_valid), 32'(exp_pv));
        if (exp_pv) check_eq("pop_data", 32'(pop_data), 32'(exp_pd));
        check_eq("level", 32'(level), 32'(m_level));
        check_eq("full", 32'(full), 32'(m_level == CAP));
        check_eq("empty", 32'(empty), 32'(m_level == 0));
        check_eq("rd_busy", 32'(rd_busy), 32'(m_phase != 0));
        check_eq("rd_timeout", 32'(rd_timeout), 32'(m_to));

        // FIFO side: a reset clears the FIFO pointers together with the arbiter
        if (reset) begin
            env_q.delete();
            rdy_cnt = 0;
        end else begin
            if (fifo_write) env_q.push_back(fifo_data_write);
            if (fifo_read) begin
                env_rdata = (env_q.size() > 0) ? env_q.pop_front() : 8'h00;
                rdy_cnt   = hold_ready ? 0 : int'($urandom_range(1, 3));
            end
        end

        if (reset) begin
            model_reset();
        end else begin
            exp_fw = (g >= 0);
            if (g >= 0) begin
                exp_fdw = p_data[g];
                exp_q.push_back(p_data[g]);
                m_ptr = (g + 1) % N;
                m_level++;
            end
            if (decide) m_level--;
            exp_pv = 0;
            case (m_phase)
                0: if (decide) begin
                    m_phase = 1;
                    m_pend  = exp_q.pop_front();
                end
                1: begin
                    m_phase = 2;
                    m_wcnt  = 0;
                end
                default: begin
                    if (fifo_data_ready) begin
                        m_phase = 0;
                        exp_pv  = 1;
                        exp_pd  = m_pend;
                    end else begin
`ifdef FIFO_ARB_WATCHDOG_EN
                        m_wcnt++;
                        if (m_wcnt == 4) begin
                            m_phase = 0;
                            m_to    = 1;
                        end
`endif
                    end
                end
            endcase
            exp_fr = (m_phase == 1);
        end

        // Producers hold request and data until granted
        for (int i = 0; i < N; i++) begin
            if (g == i || !p_req[i]) begin
                p_req[i]  = ($urandom_range(0, 99) < req_pct);
                p_data[i] = fixed_data ? 8'(8'hA0 + i) : 8'($urandom);
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            drive();
            @(negedge clk);
            evaluate();
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; req_data = '0; pop_req = 1'b0;
        fifo_data_ready = 1'b0; fifo_data_read = 8'h00;
        p_req = '0;
        for (int i = 0; i < N; i++) p_data[i] = 8'h00;
        req_pct = 0; pop_pct = 0; fixed_data = 1'b0; rst_drv = 1'b0; hold_ready = 1'b0;
        rdy_cnt = 0; env_rdata = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_fifo_data_write", 32'(fifo_data_write), 32'h0);
        check_eq("reset_pop_data", 32'(pop_data), 32'h0);

        // Idle, with pulls against an empty FIFO
        pop_pct = 30;
        run_cycles(8);

        // Fill to capacity with all producers requesting fixed bytes
        pop_pct = 0; req_pct = 100; fixed_data = 1'b1;
        run_cycles(25);

        // Stay near full with concurrent pulls
        pop_pct = 50; fixed_data = 1'b0;
        run_cycles(80);

        // General random traffic
        req_pct = 30; pop_pct = 40;
        run_cycles(300);

        // Reset in mid-operation
        rst_drv = 1'b1;
        run_cycles(2);
        rst_drv = 1'b0;
        req_pct = 50; pop_pct = 30;
        run_cycles(200);

`ifdef FIFO_ARB_WATCHDOG_EN
        // FIFO stops answering pulls
        hold_ready = 1'b1; req_pct = 30; pop_pct = 50;
        run_cycles(60);
        hold_ready = 1'b0;
        run_cycles(40);
        rst_drv = 1'b1;
        run_cycles(2);
        rst_drv = 1'b0;
        run_cycles(20);
`endif

        // Drain, then keep pulling while empty
        req_pct = 0; pop_pct = 60;
        run_cycles(120);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_arbiter.md
Name: fifo_arbiter

Overview:
- Shares one 8-bit, 16-entry FIFO between NUM_REQ producers, using round-robin write arbitration.
- Sequences the FIFO read side for a single consumer.
- Keeps the authoritative occupancy count, so the FIFO is never overrun and no read is issued while it is empty.
- Sits between the producer channels and the FIFO's write/read/dataReadReady interface.

Parameters:
NUM_REQ, 4, number of producer ports (2..8)
DATA_W, 8, data width
DEPTH, 16, FIFO storage depth; usable capacity CAP = DEPTH-1 = 15
LVL_W, 5, width of level output (clog2(DEPTH)+1)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  producer i requests a push; held until granted
req_data  in  NUM_REQ*DATA_W  producer i byte at [i*DATA_W +: DATA_W]
grant  out  NUM_REQ  one-hot, combinational; producer i's byte is accepted this cycle
fifo_write  out  1  registered push strobe to FIFO
fifo_data_write  out  DATA_W  registered push data
fifo_read  out  1  registered pull strobe to FIFO
fifo_data_ready  in  1  FIFO pull-complete pulse
fifo_data_read  in  DATA_W  FIFO pull data
pop_req  in  1  consumer pull request pulse
pop_valid  out  1  one-cycle pulse; pop_data valid
pop_data  out  DATA_W  captured read byte
level  out  LVL_W  current occupancy, 0..CAP
full  out  1  level == CAP
empty  out  1  level == 0
rd_busy  out  1  read FSM not in RD_IDLE
rd_timeout  out  1  sticky watchdog flag (see Optional Feature)

Behaviour:
Reset values:
- Outputs: fifo_write=0, fifo_read=0, pop_valid=0, pop_data=0, fifo_data_write=0, level=0, empty=1, full=0, rd_timeout=0, rd_busy=0.
- Internal: rr_ptr=0, read FSM=RD_IDLE.
- Reset mid-operation abandons any in-flight push or pull.
- Integration resets the FIFO pointers in the same cycle so that level and the FIFO stay consistent.

Write arbitration:
- A push is allowed in a cycle when level_next_free = (level < CAP) or (a pull is issued this cycle).
- When allowed and req != 0, the winner is the first set bit at or after rr_ptr, scanning upward with wrap.
- grant[winner]=1 combinationally in the same cycle. Otherwise grant=0.
- On the next edge: fifo_write<=1, fifo_data_write<=req_data[winner], rr_ptr<=winner+1 (mod NUM_REQ).
- Latency: req sampled in cycle N, FIFO push strobe in cycle N+1.
- Maximum throughput is one push per cycle. Back-to-back grants to the same producer are legal when it is the only requester.
- When full with no concurrent pull, grant=0 and producers hold req and data.

Read FSM:
- RD_IDLE: on pop_req && level != 0, go to RD_ISSUE. pop_req while empty is ignored, with no error.
- RD_ISSUE: fifo_read=1 for exactly this one cycle; go to RD_WAIT.
- RD_WAIT: on fifo_data_ready, pop_data<=fifo_data_read, pop_valid<=1 for one cycle, and return to RD_IDLE.
- pop_req outside RD_IDLE is ignored; no queuing.
- The earliest next fifo_read is 3 cycles after the previous one.

Level accounting:
- +1 on a grant cycle, -1 on the RD_ISSUE entry decision, unchanged when both happen in the same cycle.
- Never exceeds CAP and never underflows. full and empty are registered from level.

Optional Feature:
- Macro: FIFO_ARB_WATCHDOG_EN.
- Defined:
  - RD_WAIT counts cycles using a 3-bit counter cleared on entry.
  - If fifo_data_ready has not arrived after 4 cycles in RD_WAIT, the FSM returns to RD_IDLE with no pop_valid, and rd_timeout<=1.
  - rd_timeout is sticky until reset.
  - level is not restored, because the FIFO pointer has already advanced.
- Not defined: RD_WAIT waits indefinitely, and rd_timeout is tied to 0.

Test Plan:
- Reset, then req=4'b0000 -> level=0, empty=1, grant=0, fifo_write=0 every cycle.
- req=4'b1111 held with distinct data 0xA0..0xA3 -> grants 0,1,2,3,0,... one per cycle; fifo_write each following cycle with matching data; level stops at 15, full=1, grant=0 thereafter.
- level=15, req=4'b0010, pop_req pulse in the same cycle -> grant[1]=1, fifo_read=1 next cycle, level stays 15.
- Push 0x5A, then pop_req -> fifo_read one cycle later; when FIFO returns dataReadReady, pop_valid pulse with pop_data=0x5A; level back to 0, empty=1.
- Empty FIFO, pop_req -> no fifo_read, rd_busy stays 0; also pop_req during RD_WAIT -> ignored, only one fifo_read.
- With FIFO_ARB_WATCHDOG_EN, fifo_data_ready held 0 -> return to RD_IDLE after 4 RD_WAIT cycles, rd_timeout=1 until reset, no pop_valid.
